// File: rtl/fp16_pkg.sv
// Shared FP16 decode constants, FSM state and operand class encodings for the
// FP16 -> int16 converter.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] INT_MAX = 16'h7FFF;
  localparam logic [15:0] INT_MIN = 16'h8000;

  localparam logic [EXP_W-1:0] EXP_BIAS       = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] EXP_SPECIAL    = '1;
  localparam logic [EXP_W-1:0] EXP_TOP_FINITE = EXP_W'(2 * BIAS);
  // Unbiased exponent at which the significand's binary point sits at bit 0.
  localparam logic [EXP_W-1:0] K_UNITY        = EXP_W'(MAN_W);

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    NEG,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_NAN,
    CLS_INF,
    CLS_SMALL,
    CLS_MIN,
    CLS_OVF
  } class_t;

  function automatic logic [15:0] overflow_value(input logic sign, input logic saturate);
    if (!saturate) return INT_MIN;
    return sign ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/fp16_to_int16_converter_if.sv
// Issue (valid/ready) and writeback (valid/ready) ports of the converter.
interface fp16_to_int16_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_fp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_int;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_int, out_flags
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_int, out_flags
  );
endinterface

// File: rtl/fp16_unpack.sv
// Combinational FP16 field decode: classifies the operand, yields the fixed
// result/flags for special classes and the alignment shift for normal ones.
module fp16_unpack
  import fp16_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic [15:0]    fp,
  output logic           sign,
  output logic [MAN_W:0] sig,
  output class_t         cls,
  output logic [15:0]    spec_val,
  output logic [2:0]     spec_flags,
  output logic [4:0]     shift_n,
  output logic           shift_left
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic [EXP_W-1:0] k;

  assign sign  = fp[15];
  assign exp_f = fp[14:10];
  assign man_f = fp[9:0];
  assign sig   = {1'b1, man_f};
  assign k     = exp_f - EXP_BIAS;

  always_comb begin
    cls        = CLS_NORMAL;
    spec_val   = '0;
    spec_flags = '0;
    if (exp_f == EXP_SPECIAL) begin
      if (man_f != '0) begin
        cls = CLS_NAN;
        spec_flags[FLAG_INVALID] = 1'b1;
      end else begin
        cls = CLS_INF;
        spec_val = overflow_value(sign, SATURATE);
        spec_flags[FLAG_OVERFLOW] = 1'b1;
      end
    end else if (exp_f < EXP_BIAS) begin
      cls = CLS_SMALL;
      spec_flags[FLAG_INEXACT] = |{exp_f, man_f};
    end else if (exp_f == EXP_TOP_FINITE) begin
      // -32768 is the only value with k=15 that is representable.
      if (sign && man_f == '0) begin
        cls = CLS_MIN;
        spec_val = INT_MIN;
      end else begin
        cls = CLS_OVF;
        spec_val = overflow_value(sign, SATURATE);
        spec_flags[FLAG_OVERFLOW] = 1'b1;
      end
    end
  end

  always_comb begin
    shift_n    = '0;
    shift_left = 1'b0;
    if (cls == CLS_NORMAL) begin
      if (k >= K_UNITY) begin
        shift_left = 1'b1;
        shift_n    = k - K_UNITY;
      end else begin
        shift_n    = K_UNITY - k;
      end
    end
  end

endmodule

// File: rtl/fp16_to_int16_converter.sv
// FP16 -> int16 (round toward zero) functional unit; aligns the magnitude one
// bit per cycle, then applies the sign and presents the result until taken.
module fp16_to_int16_converter
  import fp16_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  fp16_to_int16_converter_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready high
  // SHIFT | aligning magnitude, one bit per cycle, cnt bits remaining
  // NEG   | apply sign (or load special value) into the output registers
  // DONE  | raise out_valid, hold result until out_ready
  state_t      state;
  logic [4:0]  cnt;
  logic [15:0] mag;
  logic        sticky;
  logic        sign_r;
  logic        special_r;
  logic        left_r;
  logic [15:0] spec_val_r;
  logic [2:0]  spec_flags_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [15:0] out_int_r;
  logic [2:0]  out_flags_r;

  logic           u_sign;
  logic [MAN_W:0] u_sig;
  class_t         u_cls;
  logic [15:0]    u_spec_val;
  logic [2:0]     u_spec_flags;
  logic [4:0]     u_n;
  logic           u_left;

  fp16_unpack #(.SATURATE(SATURATE)) u_unpack (
    .fp         (bus.in_fp),
    .sign       (u_sign),
    .sig        (u_sig),
    .cls        (u_cls),
    .spec_val   (u_spec_val),
    .spec_flags (u_spec_flags),
    .shift_n    (u_n),
    .shift_left (u_left)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_int   = out_int_r;
  assign bus.out_flags = out_flags_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mag          <= '0;
      sticky       <= 1'b0;
      sign_r       <= 1'b0;
      special_r    <= 1'b0;
      left_r       <= 1'b0;
      spec_val_r   <= '0;
      spec_flags_r <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_int_r    <= '0;
      out_flags_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r   <= 1'b0;
            sign_r       <= u_sign;
            special_r    <= (u_cls != CLS_NORMAL);
            spec_val_r   <= u_spec_val;
            spec_flags_r <= u_spec_flags;
            mag          <= {{(15 - MAN_W){1'b0}}, u_sig};
            sticky       <= 1'b0;
            left_r       <= u_left;
            cnt          <= u_n;
            state        <= (u_n == '0) ? NEG : SHIFT;
          end
        end
        SHIFT: begin
          // Left shifts never exceed 4 bits, so nothing is lost off the top.
          if (left_r) begin
            mag <= {mag[14:0], 1'b0};
          end else begin
            mag    <= {1'b0, mag[15:1]};
            sticky <= sticky | mag[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= NEG;
        end
        NEG: begin
          if (special_r) begin
            out_int_r   <= spec_val_r;
            out_flags_r <= spec_flags_r;
          end else begin
            out_int_r   <= sign_r ? (16'd0 - mag) : mag;
            out_flags_r <= '0;
            out_flags_r[FLAG_INEXACT] <= sticky;
          end
          state <= DONE;
        end
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_to_int16_converter.sv
// Directed-vector bench: saturating and wrapping converters run in lockstep.
module tb_fp16_to_int16_converter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] cur_fp = '0;

  always #5 clk = ~clk;

  fp16_to_int16_converter_if bus0 ();
  fp16_to_int16_converter_if bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_fp     = bus0.in_fp;
  assign bus1.out_ready = bus0.out_ready;

  fp16_to_int16_converter #(.SATURATE(1'b1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  fp16_to_int16_converter #(.SATURATE(1'b0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic [15:0] fp;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
    logic [2:0]  exp_flags;
    int          exp_lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s fp=%h: got %0h expected %0h", nm, cur_fp, act, expv);
    end
  endtask

  // Issues one operand and returns cycles from accept edge to out_valid (0 = timeout).
  task automatic do_op(input logic [15:0] fp, output int lat);
    int guard;
    guard = 0;
    cur_fp = fp;
    while (!(bus0.in_ready && bus1.in_ready) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus0.in_fp    = fp;
    bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.in_fp    = ~fp;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus0.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    check("valid_drop", {31'd0, bus0.out_valid}, 32'd0);
    check("ready_back", {31'd0, bus0.in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{16'h3C00, 16'h0001, 16'h0001, 3'b000, 12};
    vecs[1]  = '{16'hC500, 16'hFFFB, 16'hFFFB, 3'b000, 10};
    vecs[2]  = '{16'h6800, 16'h0800, 16'h0800, 3'b000, 3};
    vecs[3]  = '{16'h3E00, 16'h0001, 16'h0001, 3'b001, 12};
    vecs[4]  = '{16'h3800, 16'h0000, 16'h0000, 3'b001, 2};
    vecs[5]  = '{16'h7BFF, 16'h7FFF, 16'h8000, 3'b010, 2};
    vecs[6]  = '{16'hF800, 16'h8000, 16'h8000, 3'b000, 2};
    vecs[7]  = '{16'h7E00, 16'h0000, 16'h0000, 3'b100, 2};
    vecs[8]  = '{16'h0000, 16'h0000, 16'h0000, 3'b000, 2};
    vecs[9]  = '{16'h7C00, 16'h7FFF, 16'h8000, 3'b010, 2};
    vecs[10] = '{16'hFC00, 16'h8000, 16'h8000, 3'b010, 2};
    vecs[11] = '{16'h77FF, 16'h7FF0, 16'h7FF0, 3'b000, 6};
    vecs[12] = '{16'hF7FF, 16'h8010, 16'h8010, 3'b000, 6};
    vecs[13] = '{16'h0001, 16'h0000, 16'h0000, 3'b001, 2};
    vecs[14] = '{16'h4900, 16'h000A, 16'h000A, 3'b000, 9};
    vecs[15] = '{16'h4248, 16'h0003, 16'h0003, 3'b001, 11};
    vecs[16] = '{16'hC248, 16'hFFFD, 16'hFFFD, 3'b001, 11};
    vecs[17] = '{16'hF801, 16'h8000, 16'h8000, 3'b010, 2};
    vecs[18] = '{16'h6400, 16'h0400, 16'h0400, 3'b000, 2};
    vecs[19] = '{16'h8000, 16'h0000, 16'h0000, 3'b000, 2};

    reset          = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_fp     = '0;
    bus0.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready",  {31'd0, bus0.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    check("rst_out_int",   {16'd0, bus0.out_int}, 32'd0);
    check("rst_out_flags", {29'd0, bus0.out_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].fp, lat);
      check("latency",    lat, vecs[i].exp_lat);
      check("int_sat",    {16'd0, bus0.out_int}, {16'd0, vecs[i].exp_sat});
      check("flags_sat",  {29'd0, bus0.out_flags}, {29'd0, vecs[i].exp_flags});
      check("valid_wrap", {31'd0, bus1.out_valid}, 32'd1);
      check("int_wrap",   {16'd0, bus1.out_int}, {16'd0, vecs[i].exp_wrap});
      check("flags_wrap", {29'd0, bus1.out_flags}, {29'd0, vecs[i].exp_flags});
      consume();
    end

    // Backpressure: result must hold while a competing operand is offered.
    do_op(16'h3C00, lat);
    check("bp_latency", lat, 12);
    bus0.in_valid = 1'b1;
    bus0.in_fp    = 16'h4900;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("bp_valid",    {31'd0, bus0.out_valid}, 32'd1);
      check("bp_int",      {16'd0, bus0.out_int}, 32'd1);
      check("bp_in_ready", {31'd0, bus0.in_ready}, 32'd0);
    end
    bus0.in_valid = 1'b0;
    consume();
    check("bp_int_after", {16'd0, bus0.out_int}, 32'd1);

    // Reset in the middle of alignment, then a clean conversion.
    cur_fp = 16'h3C00;
    bus0.in_fp    = 16'h3C00;
    bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_int",      {16'd0, bus0.out_int}, 32'd0);
    check("mid_rst_flags",    {29'd0, bus0.out_flags}, 32'd0);
    check("mid_rst_valid",    {31'd0, bus0.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    check("mid_rst_int_wrap", {16'd0, bus1.out_int}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(16'hC500, lat);
    check("post_rst_latency", lat, 10);
    check("post_rst_int",     {16'd0, bus0.out_int}, 32'h0000FFFB);
    check("post_rst_flags",   {29'd0, bus0.out_flags}, 32'd0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
